// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter: FSM states, requester ids,
// write-mode encodings and the bit layout of the request/winner vectors.
package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_IF   = 2'd1,
    REQ_D    = 2'd2,
    REQ_DBG  = 2'd3
  } req_id_e;

  localparam logic [1:0] WM_RD  = 2'b00;
  localparam logic [1:0] WM_LO  = 2'b01;
  localparam logic [1:0] WM_HI  = 2'b10;
  localparam logic [1:0] WM_ALL = 2'b11;

  // Bit positions inside the 3-bit request and one-hot winner vectors.
  localparam int RI_IF  = 0;
  localparam int RI_D   = 1;
  localparam int RI_DBG = 2;

  function automatic req_id_e win_to_id(input logic [2:0] win);
    req_id_e id;
    id = REQ_NONE;
    if (win[RI_IF])       id = REQ_IF;
    else if (win[RI_D])   id = REQ_D;
    else if (win[RI_DBG]) id = REQ_DBG;
    return id;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational priority picker: data > fetch > debug, except a starved
// fetch request beats everything.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [2:0] req_i,
  input  logic       starve_i,
  output logic [2:0] win_o
);

  always_comb begin
    win_o = 3'b000;
    if (starve_i && req_i[RI_IF]) win_o[RI_IF]  = 1'b1;
    else if (req_i[RI_D])         win_o[RI_D]   = 1'b1;
    else if (req_i[RI_IF])        win_o[RI_IF]  = 1'b1;
    else if (req_i[RI_DBG])       win_o[RI_DBG] = 1'b1;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter sharing one memory between fetch, load/store
// and (with MEM_ARB_DBG_EN defined) a read-only debug port.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = 8,
  parameter int DW         = 64,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic [1:0]    d_wmode,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic [1:0]    mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
`ifdef MEM_ARB_DBG_EN
  input  logic          dbg_req,
  input  logic [AW-1:0] dbg_addr,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
`endif
  output state_e        state_o
);

  localparam int LW = $clog2(MEM_LAT + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  state_e        state_q;
  logic [LW-1:0] lat_cnt_q;
  logic [SW-1:0] starve_cnt_q;
  req_id_e       owner_q;
  logic          if_rvalid_q, d_rvalid_q;
  logic [DW-1:0] if_rdata_q, d_rdata_q;

  logic          arb_ok, starve_hit, win_is_read;
  logic [2:0]    req_vec, win;
  logic          dbg_req_w;
  logic [AW-1:0] dbg_addr_w;

`ifdef MEM_ARB_DBG_EN
  logic          dbg_rvalid_q;
  logic [DW-1:0] dbg_rdata_q;
  assign dbg_req_w  = dbg_req;
  assign dbg_addr_w = dbg_addr;
  assign dbg_gnt    = win[RI_DBG];
  assign dbg_rvalid = dbg_rvalid_q;
  assign dbg_rdata  = dbg_rdata_q;
`else
  assign dbg_req_w  = 1'b0;
  assign dbg_addr_w = '0;
`endif

  // Grants only from IDLE and never while reset is asserted.
  assign arb_ok     = (state_q == IDLE) && !reset;
  assign req_vec    = arb_ok ? {dbg_req_w, d_req, if_req} : 3'b000;
  assign starve_hit = (starve_cnt_q == SW'(STARVE_MAX));

  mem_arb_pick u_pick (
    .req_i    (req_vec),
    .starve_i (starve_hit),
    .win_o    (win)
  );

  assign if_gnt      = win[RI_IF];
  assign d_gnt       = win[RI_D];
  assign mem_en      = |win;
  assign mem_we      = win[RI_D] ? d_wmode : WM_RD;
  assign win_is_read = win[RI_IF] | win[RI_DBG] | (win[RI_D] && (d_wmode == WM_RD));

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    if (win[RI_D]) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (win[RI_IF]) begin
      mem_addr = if_addr;
    end else if (win[RI_DBG]) begin
      mem_addr = dbg_addr_w;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      lat_cnt_q    <= '0;
      starve_cnt_q <= '0;
      owner_q      <= REQ_NONE;
      if_rvalid_q  <= 1'b0;
      d_rvalid_q   <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
`ifdef MEM_ARB_DBG_EN
      dbg_rvalid_q <= 1'b0;
      dbg_rdata_q  <= '0;
`endif
    end else begin
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
`ifdef MEM_ARB_DBG_EN
      dbg_rvalid_q <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          // Only fetch losing to data counts as starvation; debug never does.
          if (win[RI_IF])
            starve_cnt_q <= '0;
          else if (win[RI_D] && if_req && !starve_hit)
            starve_cnt_q <= starve_cnt_q + SW'(1);
          if (win_is_read) begin
            state_q   <= BUSY;
            lat_cnt_q <= LW'(MEM_LAT);
            owner_q   <= win_to_id(win);
          end
        end
        BUSY: begin
          if (lat_cnt_q == LW'(1)) begin
            state_q   <= IDLE;
            lat_cnt_q <= '0;
            unique case (owner_q)
              REQ_IF: begin
                if_rvalid_q <= 1'b1;
                if_rdata_q  <= mem_rdata;
              end
              REQ_D: begin
                d_rvalid_q <= 1'b1;
                d_rdata_q  <= mem_rdata;
              end
`ifdef MEM_ARB_DBG_EN
              REQ_DBG: begin
                dbg_rvalid_q <= 1'b1;
                dbg_rdata_q  <= mem_rdata;
              end
`endif
              default: ;
            endcase
          end else begin
            lat_cnt_q <= lat_cnt_q - LW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;
  assign state_o   = state_q;

endmodule
